// File: rtl/mrdy_waitgen_pkg.sv
// Shared types and constants for the 6809E wait-state generator.
// Holds the FSM encoding, the device-class type and the {QX,EX} phase codes.
package mrdy_waitgen_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCount   = 2'd1,
        StExtWait = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        DevNone,
        DevRom,
        DevRam,
        DevUart,
        DevExt
    } dev_e;

    // Sampled {QX,EX}: 11 is the E-rising latch point, 01 is the E-high stretch point.
    localparam logic [1:0] PhLatch   = 2'b11;
    localparam logic [1:0] PhStretch = 2'b01;

    // Wait counts larger than the timeout can never complete, so clip them to it.
    function automatic logic [7:0] clip_ws(input int unsigned ws, input int unsigned limit);
        int unsigned v;
        v = (ws > limit) ? limit : ws;
        if (v > 255) begin
            v = 255;
        end
        return v[7:0];
    endfunction

endpackage

// File: rtl/mrdy_waitgen_sync2.sv
// Two-flop synchroniser for asynchronous active-low request inputs.
// Resets to 1 so an idle (deasserted) request is seen during and after reset.
module mrdy_waitgen_sync2 (
    input  logic CLKX4,
    input  logic nRESET,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge CLKX4 or negedge nRESET) begin
        if (!nRESET) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/mrdy_waitgen.sv
// Wait-state generator: stretches E-high by holding MRDY low for a per-device count,
// extends EXT cycles via synchronised nEXTWAIT, and guards every cycle with a timeout.
module mrdy_waitgen
    import mrdy_waitgen_pkg::*;
#(
    parameter int unsigned WS_ROM  = 0,
    parameter int unsigned WS_RAM  = 0,
    parameter int unsigned WS_UART = 2,
    parameter int unsigned WS_EXT  = 1,
    parameter int unsigned TIMEOUT = 63
) (
    input  logic CLKX4,
    input  logic nRESET,
    input  logic QX,
    input  logic EX,
    input  logic BA,
    input  logic nCSROM0,
    input  logic nCSROM1,
    input  logic nCSRAM,
    input  logic nCSUART,
    input  logic nCSEXT,
    input  logic nEXTWAIT,
    input  logic BUSERR_CLR,
    output logic MRDY,
    output logic BUSERR,
    output logic STRETCH
);

    localparam logic [7:0] WsRom   = clip_ws(WS_ROM, TIMEOUT);
    localparam logic [7:0] WsRam   = clip_ws(WS_RAM, TIMEOUT);
    localparam logic [7:0] WsUart  = clip_ws(WS_UART, TIMEOUT);
    localparam logic [7:0] WsExt   = clip_ws(WS_EXT, TIMEOUT);
    localparam logic [7:0] Timeout = clip_ws(TIMEOUT, 255);

    logic       nextwait_s;
    logic [1:0] phase;
    dev_e       dev;
    logic [7:0] ws_n;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] tot_q, tot_d;
    logic       ext_q, ext_d;
    logic       mrdy_q, mrdy_d;
    logic       buserr_q, buserr_d;
    logic       stretch_q;

    logic [7:0] cnt_dec;
    logic [7:0] tot_inc;
    logic       timeout_hit;
    logic       buserr_set;

    mrdy_waitgen_sync2 u_sync_extwait (
        .CLKX4  (CLKX4),
        .nRESET (nRESET),
        .d      (nEXTWAIT),
        .q      (nextwait_s)
    );

    assign phase = {QX, EX};

    // A granted bus (BA=1) is treated as no device selected.
    always_comb begin
        dev = DevNone;
        if (!BA) begin
            if (!nCSUART) begin
                dev = DevUart;
            end else if (!nCSEXT) begin
                dev = DevExt;
            end else if (!nCSROM0 || !nCSROM1) begin
                dev = DevRom;
            end else if (!nCSRAM) begin
                dev = DevRam;
            end
        end
    end

    always_comb begin
        ws_n = 8'd0;
        case (dev)
            DevRom:  ws_n = WsRom;
            DevRam:  ws_n = WsRam;
            DevUart: ws_n = WsUart;
            DevExt:  ws_n = WsExt;
            default: ws_n = 8'd0;
        endcase
    end

    assign cnt_dec     = cnt_q - 8'd1;
    assign tot_inc     = (tot_q == 8'hFF) ? tot_q : tot_q + 8'd1;
    assign timeout_hit = ({1'b0, tot_q} + 9'd1) == {1'b0, Timeout};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tot_d      = tot_q;
        ext_d      = ext_q;
        mrdy_d     = mrdy_q;
        buserr_set = 1'b0;

        case (state_q)
            StIdle: begin
                mrdy_d = 1'b1;
                if (phase == PhLatch) begin
                    cnt_d = ws_n;
                    tot_d = 8'd0;
                    ext_d = (dev == DevExt);
                    if (ws_n != 8'd0) begin
                        mrdy_d  = 1'b0;
                        state_d = StCount;
                    end else if ((dev == DevExt) && !nextwait_s) begin
                        mrdy_d  = 1'b0;
                        state_d = StExtWait;
                    end
                end
            end
            StCount: begin
                if (phase == PhStretch) begin
                    cnt_d = cnt_dec;
                    tot_d = tot_inc;
                    if (timeout_hit) begin
                        mrdy_d     = 1'b1;
                        buserr_set = 1'b1;
                        state_d    = StIdle;
                    end else if (cnt_dec == 8'd0) begin
                        if (ext_q && !nextwait_s) begin
                            state_d = StExtWait;
                        end else begin
                            mrdy_d  = 1'b1;
                            state_d = StIdle;
                        end
                    end
                end else begin
                    // Clock generator left the stretch point on its own; abandon the cycle.
                    mrdy_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            StExtWait: begin
                if (phase == PhStretch) begin
                    tot_d = tot_inc;
                    if (timeout_hit) begin
                        mrdy_d     = 1'b1;
                        buserr_set = 1'b1;
                        state_d    = StIdle;
                    end else if (nextwait_s) begin
                        mrdy_d  = 1'b1;
                        state_d = StIdle;
                    end
                end else begin
                    mrdy_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                mrdy_d  = 1'b1;
                state_d = StIdle;
            end
        endcase

        if (buserr_set) begin
            buserr_d = 1'b1;
        end else if (BUSERR_CLR) begin
            buserr_d = 1'b0;
        end else begin
            buserr_d = buserr_q;
        end
    end

    always_ff @(posedge CLKX4 or negedge nRESET) begin
        if (!nRESET) begin
            state_q   <= StIdle;
            cnt_q     <= 8'd0;
            tot_q     <= 8'd0;
            ext_q     <= 1'b0;
            mrdy_q    <= 1'b1;
            buserr_q  <= 1'b0;
            stretch_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tot_q     <= tot_d;
            ext_q     <= ext_d;
            mrdy_q    <= mrdy_d;
            buserr_q  <= buserr_d;
            stretch_q <= ~mrdy_d;
        end
    end

    assign MRDY    = mrdy_q;
    assign BUSERR  = buserr_q;
    assign STRETCH = stretch_q;

endmodule
